cfu_hsv2rgb_pipe: RTL and testbench
===================================

Name: cfu_hsv2rgb_pipe

Overview:
Pipelined, back-pressure-aware HSV-to-RGB custom function unit that plugs into the CPU's CFU command/response bus. It is the successor to the single-cycle combinational converter, and adds:
- a real valid/ready handshake and a parametrised pipeline depth;
- a brightness-scale mode;
- an in-order conversion counter readable through the same bus.

Parameters:
- LATENCY, 3: cycles from command accept to rsp_valid. Legal range 3..6. Stages beyond 3 are extra output retiming registers.
- SCALE_EN, 1: 1 implements funct 1 (scaled convert). 0 makes funct 1 behave as unsupported.
- CNT_W, 32: width of the conversion counter. Legal range 1..32; zero-extended into outputs_0.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset. Asserting low clears all state immediately; release is synchronous to clk.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_payload_function_id  in  10  [2:0] = funct; [9:3] ignored.
- cmd_payload_inputs_0  in  32  h=[31:16] (8.8 hue: integer sector.fraction), s=[15:8], v=[7:0].
- cmd_payload_inputs_1  in  32  funct 1: scale k=[7:0]; other bits ignored.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_payload_response_ok  out  1  0 for unsupported funct.
- rsp_payload_outputs_0  out  32  result.

Behaviour:
- Functions:
  - 0: convert.
  - 1: convert then scale.
  - 2: read counter.
  - 3: read counter then clear it.
  - 4..7: unsupported. Response still issued, ok=0, outputs 0.
- Reset (reset low):
  - All stage valids, counter, rsp_valid, rsp_payload_outputs_0 and response_ok go to 0.
  - cmd_ready is forced 0.
  - In-flight commands are dropped with no response.
- Pipeline control: one global advance enable, adv = !(rsp_valid && !rsp_ready).
  - cmd_ready = adv, while reset is high.
  - When adv=0 every stage holds; payload and valid stay stable.
  - Back-to-back throughput is 1 command per cycle.
  - Responses return in command order.
- Conversion arithmetic. All products are unsigned; ">>8" truncates.
  - sec = h[15:8] mod 6; f = h[7:0].
  - p = (v*(255-s))>>8
  - q = (v*(255-((s*f)>>8)))>>8
  - t = (v*(255-((s*(255-f))>>8)))>>8
- Sector to (r,g,b):
  - 0 → (v,t,p)
  - 1 → (q,v,p)
  - 2 → (p,v,t)
  - 3 → (p,q,v)
  - 4 → (t,p,v)
  - 5 → (v,p,q)
- s==0 overrides the table and gives (v,v,v) exactly.
- Output packing: outputs_0 = {8'h00, r, g, b}.
- Scale (funct 1): each channel becomes (c*(k+1))>>8. So k=255 is identity and k=0 gives 0.
- Stage split:
  - S1: mod-6 and s*f, s*(255-f) products.
  - S2: v products.
  - S3: sector mux, override and scale.
  - Stages 4..LATENCY: pass-through registers.
- Counter:
  - Increments (wrapping at 2^CNT_W) on each accepted funct 0, or funct 1 when SCALE_EN=1.
  - Funct 2/3 sample the counter at accept. The sampled value travels down the pipe so it is ordered against conversions.
  - Funct 3 clears the counter at accept and returns the pre-clear value. A conversion accepted on the next cycle counts as 1.
- Only one command is accepted per cycle, so increment and clear can never coincide.

Decomposition:
- Package hsv2rgb_pkg holds:
  - funct encodings FN_CONV=0, FN_SCALE=1, FN_CNT_RD=2, FN_CNT_CLR=3;
  - the pipeline stage payload struct typedef (valid, funct, ok, sec, v, products, k, cnt);
  - the sector-to-channel-order constants.
- One combinational sub-module, hsv2rgb_sector_mix. Inputs sec, s, v, p, q, t, k, scale_en; output r, g, b. It is reusable by later pixel blocks.

Test Plan:
- Funct 0, inputs_0=0x0000FFFF → outputs 0x00FF0000, ok=1, exactly LATENCY cycles after accept with rsp_ready=1.
- Funct 0 with 0x0200FFFF → 0x0000FF00. Then 0x0680FFFF (sector wrap 6→0, f=0x80) → 0x00FF8000. Then 0x12340080 (s=0) → 0x00808080. Send back-to-back; all four return in order on consecutive cycles.
- Funct 1, inputs_0=0x0000FFFF, inputs_1=0x7F → 0x007F0000. With SCALE_EN=0 the same command → ok=0, 0x00000000.
- Backpressure: hold rsp_ready=0 and offer 5 commands.
  - Exactly LATENCY are accepted, then cmd_ready=0.
  - The first response is held stable.
  - Releasing rsp_ready drains all 5 in order with no loss or duplication.
- Counter: 3 conversions then funct 3 → 3; then funct 2 → 0; funct 7 → ok=0, 0.
- Reset low mid-stream with 2 in flight: rsp_valid drops immediately. After release, no stale responses appear and funct 2 returns 0.

Source files
------------

// File: rtl/hsv2rgb_pkg.sv
// Shared types and constants for the HSV-to-RGB CFU pipeline and pixel blocks.
package hsv2rgb_pkg;

    typedef enum logic [2:0] {
        FN_CONV    = 3'd0,
        FN_SCALE   = 3'd1,
        FN_CNT_RD  = 3'd2,
        FN_CNT_CLR = 3'd3
    } funct_e;

    // Channel source selectors used by the sector table
    localparam logic [1:0] CH_V = 2'd0;
    localparam logic [1:0] CH_P = 2'd1;
    localparam logic [1:0] CH_Q = 2'd2;
    localparam logic [1:0] CH_T = 2'd3;

    // {r_sel, g_sel, b_sel} per sector; entry 0 sits in the low bits
    localparam logic [5:0][5:0] SECTOR_ORDER = {
        {CH_V, CH_P, CH_Q},
        {CH_T, CH_P, CH_V},
        {CH_P, CH_Q, CH_V},
        {CH_P, CH_V, CH_T},
        {CH_Q, CH_V, CH_P},
        {CH_V, CH_T, CH_P}
    };

    // prod_a/prod_b hold the s-products after S1; prod_a/b/c hold p/q/t after S2
    typedef struct packed {
        logic        valid;
        logic [2:0]  funct;
        logic        ok;
        logic [2:0]  sec;
        logic [7:0]  s;
        logic [7:0]  v;
        logic [7:0]  prod_a;
        logic [7:0]  prod_b;
        logic [7:0]  prod_c;
        logic [7:0]  k;
        logic [31:0] cnt;
    } stage_t;

    typedef struct packed {
        logic        valid;
        logic        ok;
        logic [31:0] data;
    } rsp_t;

endpackage

// File: rtl/hsv2rgb_sector_mix.sv
// Combinational sector-to-RGB mux with grey override and optional brightness scale.
module hsv2rgb_sector_mix
    import hsv2rgb_pkg::*;
(
    input  logic [2:0] sec,
    input  logic [7:0] s,
    input  logic [7:0] v,
    input  logic [7:0] p,
    input  logic [7:0] q,
    input  logic [7:0] t,
    input  logic [7:0] k,
    input  logic       scale_en,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b
);

    logic [5:0] order;
    logic [7:0] r_raw, g_raw, b_raw;

    function automatic logic [7:0] pick(input logic [1:0] sel, input logic [7:0] cv,
                                        input logic [7:0] cp, input logic [7:0] cq,
                                        input logic [7:0] ct);
        case (sel)
            CH_V:    return cv;
            CH_P:    return cp;
            CH_Q:    return cq;
            default: return ct;
        endcase
    endfunction

    // (c*(k+1))>>8 so that k=255 is identity and k=0 blanks the channel
    function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] kk);
        return 8'((16'(c) * (16'(kk) + 16'd1)) >> 8);
    endfunction

    always_comb begin
        order = SECTOR_ORDER[(sec > 3'd5) ? 3'd0 : sec];
        if (s == 8'd0) begin
            r_raw = v;
            g_raw = v;
            b_raw = v;
        end else begin
            r_raw = pick(order[5:4], v, p, q, t);
            g_raw = pick(order[3:2], v, p, q, t);
            b_raw = pick(order[1:0], v, p, q, t);
        end
        if (scale_en) begin
            r = scale8(r_raw, k);
            g = scale8(g_raw, k);
            b = scale8(b_raw, k);
        end else begin
            r = r_raw;
            g = g_raw;
            b = b_raw;
        end
    end

endmodule

// File: rtl/cfu_hsv2rgb_pipe.sv
// Pipelined HSV-to-RGB CFU with global-stall back-pressure and an in-order conversion counter.
module cfu_hsv2rgb_pipe
    import hsv2rgb_pkg::*;
#(
    parameter int LATENCY  = 3,
    parameter bit SCALE_EN = 1'b1,
    parameter int CNT_W    = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_payload_function_id,
    input  logic [31:0] cmd_payload_inputs_0,
    input  logic [31:0] cmd_payload_inputs_1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_payload_response_ok,
    output logic [31:0] rsp_payload_outputs_0
);

    logic             adv;
    logic             accept;
    logic [2:0]       funct_in;
    logic [7:0]       h_int, h_frac, s_in, v_in;
    logic [CNT_W-1:0] cnt_reg;
    stage_t           s1_next, s1_reg;
    stage_t           s2_next, s2_reg;
    rsp_t             rsp_next;
    rsp_t             rsp_pipe_reg [LATENCY-2];
    logic [7:0]       mix_r, mix_g, mix_b;
    logic             unused_bits;

    assign unused_bits = ^{cmd_payload_function_id[9:3], cmd_payload_inputs_1[31:8]};

    // Single stall condition shared by every stage keeps responses strictly ordered
    assign adv       = !(rsp_valid && !rsp_ready);
    assign cmd_ready = reset && adv;
    assign accept    = cmd_valid && cmd_ready;
    assign funct_in  = cmd_payload_function_id[2:0];
    assign {h_int, h_frac, s_in, v_in} = cmd_payload_inputs_0;

    always_comb begin
        s1_next        = '0;
        s1_next.valid  = accept;
        s1_next.funct  = funct_in;
        s1_next.sec    = 3'(h_int % 8'd6);
        s1_next.s      = s_in;
        s1_next.v      = v_in;
        s1_next.prod_a = 8'((16'(s_in) * 16'(h_frac)) >> 8);
        s1_next.prod_b = 8'((16'(s_in) * 16'(8'd255 - h_frac)) >> 8);
        s1_next.k      = cmd_payload_inputs_1[7:0];
        s1_next.cnt    = 32'(cnt_reg);
        case (funct_in)
            FN_CONV, FN_CNT_RD, FN_CNT_CLR: s1_next.ok = 1'b1;
            FN_SCALE:                       s1_next.ok = SCALE_EN;
            default:                        s1_next.ok = 1'b0;
        endcase
    end

    always_comb begin
        s2_next        = s1_reg;
        s2_next.prod_a = 8'((16'(s1_reg.v) * 16'(8'd255 - s1_reg.s)) >> 8);
        s2_next.prod_b = 8'((16'(s1_reg.v) * 16'(8'd255 - s1_reg.prod_a)) >> 8);
        s2_next.prod_c = 8'((16'(s1_reg.v) * 16'(8'd255 - s1_reg.prod_b)) >> 8);
    end

    hsv2rgb_sector_mix u_mix (
        .sec      (s2_reg.sec),
        .s        (s2_reg.s),
        .v        (s2_reg.v),
        .p        (s2_reg.prod_a),
        .q        (s2_reg.prod_b),
        .t        (s2_reg.prod_c),
        .k        (s2_reg.k),
        .scale_en (s2_reg.funct == FN_SCALE),
        .r        (mix_r),
        .g        (mix_g),
        .b        (mix_b)
    );

    always_comb begin
        rsp_next       = '0;
        rsp_next.valid = s2_reg.valid;
        rsp_next.ok    = s2_reg.ok;
        if (s2_reg.ok) begin
            if (s2_reg.funct == FN_CNT_RD || s2_reg.funct == FN_CNT_CLR)
                rsp_next.data = s2_reg.cnt;
            else
                rsp_next.data = {8'h00, mix_r, mix_g, mix_b};
        end
    end

    // Entries past index 0 are pure retiming stages
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_reg <= '0;
            s2_reg <= '0;
            for (int i = 0; i < LATENCY - 2; i++)
                rsp_pipe_reg[i] <= '0;
        end else if (adv) begin
            s1_reg          <= s1_next;
            s2_reg          <= s2_next;
            rsp_pipe_reg[0] <= rsp_next;
            for (int i = 1; i < LATENCY - 2; i++)
                rsp_pipe_reg[i] <= rsp_pipe_reg[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else if (accept) begin
            if (funct_in == FN_CNT_CLR)
                cnt_reg <= '0;
            else if (funct_in == FN_CONV || (funct_in == FN_SCALE && SCALE_EN))
                cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign rsp_valid               = rsp_pipe_reg[LATENCY-3].valid;
    assign rsp_payload_response_ok = rsp_pipe_reg[LATENCY-3].ok;
    assign rsp_payload_outputs_0   = rsp_pipe_reg[LATENCY-3].data;

endmodule

// File: tb/tb_cfu_hsv2rgb_pipe.sv
// Scoreboard bench: two DUTs (SCALE_EN=1 and SCALE_EN=0) share one command stream.
module tb_cfu_hsv2rgb_pipe;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [9:0]  cmd_fid = '0;
    logic [31:0] cmd_in0 = '0;
    logic [31:0] cmd_in1 = '0;
    logic        rsp_ready = 1'b1;

    logic        cmd_ready, rsp_valid, rsp_ok;
    logic [31:0] rsp_out;
    logic        cmd_ready0, rsp_valid0, rsp_ok0;
    logic [31:0] rsp_out0;

    typedef struct {
        logic [31:0] e1;
        logic        ok1;
        logic [31:0] e0;
        logic        ok0;
        bit          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_acc = 0;
    int   n_rsp = 0;
    int   base;
    bit   bp_done;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cfu_hsv2rgb_pipe #(.LATENCY(LAT), .SCALE_EN(1'b1), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_payload_function_id(cmd_fid),
        .cmd_payload_inputs_0(cmd_in0), .cmd_payload_inputs_1(cmd_in1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_payload_response_ok(rsp_ok), .rsp_payload_outputs_0(rsp_out)
    );

    cfu_hsv2rgb_pipe #(.LATENCY(LAT), .SCALE_EN(1'b0), .CNT_W(8)) dut0 (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready0),
        .cmd_payload_function_id(cmd_fid),
        .cmd_payload_inputs_0(cmd_in0), .cmd_payload_inputs_1(cmd_in1),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready),
        .rsp_payload_response_ok(rsp_ok0), .rsp_payload_outputs_0(rsp_out0)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: pops one expectation per handshaken response
    always @(negedge clk) begin
        if (reset && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got %h ok=%b expected no response", rsp_out, rsp_ok);
            end else begin
                exp_t e;
                e = sb.pop_front();
                n_rsp++;
                $display("rsp %0d: out=%h ok=%b ref=%h/%b | nosc out=%h ok=%b ref=%h/%b",
                         n_rsp, rsp_out, rsp_ok, e.e1, e.ok1, rsp_out0, rsp_ok0, e.e0, e.ok0);
                chk("out", rsp_out, e.e1);
                chk("ok", 32'(rsp_ok), 32'(e.ok1));
                chk("nosc_valid", 32'(rsp_valid0), 32'd1);
                chk("nosc_out", rsp_out0, e.e0);
                chk("nosc_ok", 32'(rsp_ok0), 32'(e.ok0));
                if (e.lat) chk("latency", 32'(cyc - e.acc), 32'(LAT));
            end
        end
    end

    // Entered and left at posedge+1
    task automatic send(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e1, input logic k1,
                        input logic [31:0] e0, input logic k0, input bit lat);
        bit   done;
        exp_t e;
        done      = 1'b0;
        cmd_valid = 1'b1;
        cmd_fid   = {7'd0, fn};
        cmd_in0   = a;
        cmd_in1   = b;
        for (int w = 0; w < 200 && !done; w++) begin
            @(negedge clk);
            if (cmd_ready) begin
                e.e1 = e1; e.ok1 = k1; e.e0 = e0; e.ok0 = k0; e.lat = lat; e.acc = cyc;
                sb.push_back(e);
                n_acc++;
                done = 1'b1;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send_timeout: fn=%0d in0=%h never accepted", fn, a);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic conv(input logic [31:0] a, input logic [31:0] e, input bit lat);
        send(3'd0, a, 32'd0, e, 1'b1, e, 1'b1, lat);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_out", rsp_out, 32'd0);
        chk("rst_ok", 32'(rsp_ok), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Single conversion, exact latency
        conv(32'h0000FFFF, 32'h00FF0000, 1'b1);
        drain();

        // Back-to-back conversions, consecutive responses
        conv(32'h0200FFFF, 32'h0000FF00, 1'b1);
        conv(32'h0680FFFF, 32'h00FF8000, 1'b1);
        conv(32'h12340080, 32'h00808080, 1'b1);
        conv(32'h0000FFFF, 32'h00FF0000, 1'b1);

        // Scaled convert; unsupported on the SCALE_EN=0 instance
        send(3'd1, 32'h0000FFFF, 32'h0000007F, 32'h007F0000, 1'b1, 32'h0, 1'b0, 1'b1);
        drain();

        // Back-pressure: LAT accepted, head response held stable, full drain
        rsp_ready = 1'b0;
        base      = n_acc;
        bp_done   = 1'b0;
        fork
            begin
                conv(32'h0000FFFF, 32'h00FF0000, 1'b0);
                conv(32'h0200FFFF, 32'h0000FF00, 1'b0);
                conv(32'h0680FFFF, 32'h00FF8000, 1'b0);
                conv(32'h12340080, 32'h00808080, 1'b0);
                conv(32'h0400FFFF, 32'h000000FF, 1'b0);
                bp_done = 1'b1;
            end
        join_none
        repeat (12) @(negedge clk);
        chk("bp_accepted", 32'(n_acc - base), 32'(LAT));
        chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
        chk("bp_hold_data", rsp_out, 32'h00FF0000);
        repeat (3) @(negedge clk);
        chk("bp_hold_data_later", rsp_out, 32'h00FF0000);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 100 && !bp_done; i++) @(posedge clk);
        chk("bp_all_sent", 32'(bp_done), 32'd1);
        @(posedge clk);
        #1;
        drain();

        // Counter: 11 conversions on dut, 10 on dut0 so far
        send(3'd3, 32'h0, 32'h0, 32'd11, 1'b1, 32'd10, 1'b1, 1'b0);
        conv(32'h0140FFFF, 32'h00BFFF00, 1'b1);
        conv(32'h0340FFFF, 32'h0000BFFF, 1'b1);
        conv(32'h051080C8, 32'h00C863C0, 1'b1);
        send(3'd3, 32'h0, 32'h0, 32'd3, 1'b1, 32'd3, 1'b1, 1'b1);
        send(3'd2, 32'h0, 32'h0, 32'd0, 1'b1, 32'd0, 1'b1, 1'b1);
        send(3'd7, 32'hFFFFFFFF, 32'hFF, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
        drain();

        // Reset with two commands in flight
        rsp_ready = 1'b0;
        conv(32'h0000FFFF, 32'h00FF0000, 1'b0);
        conv(32'h0200FFFF, 32'h0000FF00, 1'b0);
        for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
        chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
        reset = 1'b0;
        #1;
        chk("async_rst_valid", 32'(rsp_valid), 32'd0);
        chk("async_rst_ready", 32'(cmd_ready), 32'd0);
        chk("async_rst_out", rsp_out, 32'd0);
        chk("async_rst_nosc_valid", 32'(rsp_valid0), 32'd0);
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        send(3'd2, 32'h0, 32'h0, 32'd0, 1'b1, 32'd0, 1'b1, 1'b1);
        drain();
        repeat (8) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
